// File: rtl/eeg_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : eeg_sample_loader
// Description : Converts offset-binary ADC samples to Q20 double-width words
//               and streams one epoch into intermediate-result memory through
//               a 2-entry FIFO. Optional macro EEG_LOADER_DROP_COUNT_EN adds a
//               saturating dropped-sample counter output (drop_count).
// Revision    : 1.0 - initial release
// ============================================================================
module eeg_sample_loader #(
    parameter int          NUM_SAMPLES = 3840,
    parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        new_sample,
    input  logic [15:0] eeg_sample,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [29:0] wr_data,
    input  logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow
`ifdef EEG_LOADER_DROP_COUNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int                 c_cnt_w = $clog2(NUM_SAMPLES + 1);
    localparam logic [c_cnt_w-1:0] c_num   = c_cnt_w'(NUM_SAMPLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(NUM_SAMPLES - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_acc_cnt;
    logic [c_cnt_w-1:0]   r_wr_cnt;
    logic [29:0]          r_fifo [0:1];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_fifo_cnt;
    logic                 r_overflow;
    logic                 r_done;
    logic                 w_clear;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_last_wr;
    logic [29:0]          w_conv;

    // Flipping the MSB turns offset binary into two's complement; then
    // sign-extend and scale by 2^5 to land in Q20.
    assign w_conv = {{9{~eeg_sample[15]}}, ~eeg_sample[15], eeg_sample[14:0], 5'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_last_wr    = 1'b0;
        w_full       = (r_fifo_cnt == 2'd2);
        w_pop        = (r_fifo_cnt != 2'd0) && wr_ready;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = S_LOADING;
                end
            end
            S_LOADING: begin
                if (new_sample && (r_acc_cnt < c_num)) begin
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                if (w_push && (r_acc_cnt == c_last)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_wr_cnt == c_last)) begin
                    w_last_wr    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_wr;
            if (w_clear) begin
                r_acc_cnt  <= '0;
                r_wr_cnt   <= '0;
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_fifo_cnt <= 2'd0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= w_conv;
                    r_wr_ptr         <= ~r_wr_ptr;
                    r_acc_cnt        <= r_acc_cnt + c_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                    r_wr_cnt <= r_wr_cnt + c_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                    2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                    default: r_fifo_cnt <= r_fifo_cnt;
                endcase
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef EEG_LOADER_DROP_COUNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_clear) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign wr_en    = (r_fifo_cnt != 2'd0);
    assign wr_data  = r_fifo[r_rd_ptr];
    assign wr_addr  = BASE_ADDR + 16'(r_wr_cnt);
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_eeg_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_eeg_sample_loader
// Description : Scoreboard bench for eeg_sample_loader (epoch load, conversion,
//               stall/overflow, busy-start rejection, reset abort).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeg_sample_loader;

    localparam int          NUM  = 3840;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        new_sample;
    logic [15:0] eeg_sample;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [29:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef EEG_LOADER_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int          checks   = 0;
    int          errors   = 0;
    int          n_writes = 0;
    int          n_done   = 0;
    logic [15:0] exp_addr = BASE;
    logic [45:0] exp_q[$];

    always #5 clk = ~clk;

    eeg_sample_loader #(
        .NUM_SAMPLES(NUM),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .new_sample(new_sample),
        .eeg_sample(eeg_sample),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
`ifdef EEG_LOADER_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    function automatic logic [29:0] conv(input logic [15:0] s);
        int v;
        v = (int'(s) - 32768) * 32;
        return v[29:0];
    endfunction

    // One clock: observe the handshake at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [45:0] e;
        @(negedge clk);
        if (wr_en && wr_ready) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL write_data: got addr %h data %h, required addr %h data %h",
                             wr_addr, wr_data, e[45:30], e[29:0]);
                end
            end
        end
        if (done) begin
            n_done++;
            checks++;
            if (busy !== 1'b0 || n_writes !== NUM) begin
                errors++;
                $display("FAIL done_timing: got busy %b writes %0d, required busy 0 writes %0d", busy, n_writes, NUM);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [29:0] d);
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 16'd1;
    endtask

    task automatic strobe(input logic [15:0] s, input bit accept);
        eeg_sample = s;
        new_sample = 1'b1;
        if (accept) push_exp(conv(s));
        tick();
        new_sample = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending writes, required 0", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_addr = BASE;
        n_writes = 0;
        n_done   = 0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_en    !== 1'b0)  begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
        checks++; if (busy     !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done     !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++; if (wr_addr  !== BASE)  begin errors++; $display("FAIL reset_wr_addr: got %h required %h", wr_addr, BASE); end
        checks++; if (wr_data  !== 30'd0) begin errors++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
`ifdef EEG_LOADER_DROP_COUNT_EN
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
`endif
        do_reset();
    endtask

    task automatic test_full_epoch();
        logic [15:0] s;
        logic [15:0] pats [0:3];
        logic [29:0] vals [0:3];
        pats[0] = 16'h0000; vals[0] = 30'h3FF00000;
        pats[1] = 16'h8000; vals[1] = 30'h00000000;
        pats[2] = 16'hFFFF; vals[2] = 30'h000FFFE0;
        pats[3] = 16'h7FFF; vals[3] = 30'h3FFFFFE0;
        // Strobe coinciding with start in IDLE must not be loaded.
        start = 1'b1; new_sample = 1'b1; eeg_sample = 16'h1234;
        tick();
        start = 1'b0; new_sample = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b required 1", busy); end
        for (int i = 0; i < NUM; i++) begin
            s = (i < 4) ? pats[i] : 16'($urandom);
            eeg_sample = s;
            new_sample = 1'b1;
            push_exp((i < 4) ? vals[i] : conv(s));
            tick();
            new_sample = 1'b0;
            if (i == 0) begin
                checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL latency_wr_en_rise: got %b required 1", wr_en); end
            end
            if (i == 200) pulse_start(); else tick();
            if (i == 0) begin
                checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL latency_wr_en_fall: got %b required 0", wr_en); end
            end
            tick();
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            strobe(16'($urandom), 1'b0);
            tick();
        end
        drain("epoch");
        checks++; if (n_writes !== NUM) begin errors++; $display("FAIL epoch_writes: got %0d required %0d", n_writes, NUM); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL epoch_done_count: got %0d required 1", n_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL epoch_overflow: got %b required 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL epoch_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_stall();
        logic [15:0] first;
        do_reset();
        pulse_start();
        wr_ready = 1'b0;
        first = 16'hA5C3;
        for (int i = 0; i < 10; i++) begin
            strobe((i == 0) ? first : 16'($urandom), i < 2);
            checks++;
            if (wr_addr !== BASE || wr_data !== conv(first) || wr_en !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got en %b addr %h data %h, required en 1 addr %h data %h",
                         wr_en, wr_addr, wr_data, BASE, conv(first));
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow: got %b required 1", overflow); end
`ifdef EEG_LOADER_DROP_COUNT_EN
        checks++; if (drop_count !== 8'd8) begin errors++; $display("FAIL stall_drop_count: got %0d required 8", drop_count); end
`endif
        pulse_start();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL busy_start_kept_overflow: got %b required 1", overflow); end
        wr_ready = 1'b1;
        drain("stall");
        checks++; if (n_writes !== 2) begin errors++; $display("FAIL stall_writes: got %0d required 2", n_writes); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_empty: got wr_en %b required 0", wr_en); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            strobe(16'($urandom), 1'b1);
            tick();
        end
        strobe(16'h4321, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_clear: got en %b busy %b required 0 0", wr_en, busy); end
        checks++; if (n_writes !== 100) begin errors++; $display("FAIL abort_writes: got %0d required 100", n_writes); end
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_addr = BASE;
        n_writes = 0;
        tick();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            strobe(16'($urandom), 1'b1);
            tick();
        end
        drain("restart");
        checks++; if (n_writes !== 5) begin errors++; $display("FAIL restart_writes: got %0d required 5", n_writes); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d required 0", n_done); end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        new_sample = 1'b0;
        eeg_sample = 16'h0000;
        wr_ready   = 1'b1;
        test_reset();
        test_full_epoch();
        test_stall();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeg_sample_loader.md
EEG_SAMPLE_LOADER -- requirements
Module: eeg_sample_loader

Interface
REQ-001 Parameter NUM_SAMPLES, default NUM_PATCHES*PATCH_LEN (3840): number of samples loaded per epoch.
REQ-002 Parameter BASE_ADDR, default mem_map[EEG_INPUT_MEM] (0): first intermediate-result write address.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins an epoch load; CIM is in EEG_LOAD.
REQ-006 new_sample  input  1  one-cycle strobe; eeg_sample valid this cycle.
REQ-007 eeg_sample  input  16 (AdcData_t)  unsigned offset-binary ADC word.
REQ-008 wr_en  output  1  intermediate-result write request.
REQ-009 wr_addr  output  16 (IntResAddr_t)  write address.
REQ-010 wr_data  output  30 (IntResDouble_t)  double-width fixed-point sample, Q20 (Q_STO_INT_RES_DOUBLE).
REQ-011 wr_ready  input  1  memory accepts the write this cycle when wr_en & wr_ready.
REQ-012 busy  output  1  high in LOADING or DRAIN.
REQ-013 done  output  1  one-cycle pulse when the last write is accepted.
REQ-014 overflow  output  1  sticky; a sample was dropped this epoch.

Function
REQ-015 FSM states IDLE, LOADING, DRAIN; IDLE->LOADING on start; LOADING->DRAIN when NUM_SAMPLES samples accepted; DRAIN->IDLE when NUM_SAMPLES writes accepted.
REQ-016 Conversion: wr_data = sign-extend((eeg_sample - 32768) as signed 16b) << 5; 0x0000 -> -2^20, 0x8000 -> 0, 0xFFFF -> 2^20-32.
REQ-017 Samples buffered in a 2-entry FIFO holding converted words; push on new_sample in LOADING while accepted-count < NUM_SAMPLES.
REQ-018 new_sample when FIFO full and no pop that cycle: sample dropped, overflow set, accepted-count unchanged.
REQ-019 FIFO full with pop in same cycle: push accepted, no drop.
REQ-020 wr_en registered: high whenever FIFO non-empty; wr_addr/wr_data = FIFO head, held stable until wr_ready.
REQ-021 Latency: sample accepted at edge N into empty FIFO -> wr_en high after edge N; with wr_ready high, write completes at edge N+1.
REQ-022 wr_addr = BASE_ADDR + write-count; write-count increments per accepted write, 0..NUM_SAMPLES-1, no wrap.
REQ-023 new_sample in IDLE or DRAIN ignored, no overflow.
REQ-024 start while busy ignored; start and new_sample same cycle in IDLE: sample ignored.
REQ-025 start clears overflow, both counters and FIFO.
REQ-026 done asserts the cycle after the final write handshake, concurrent with return to IDLE; busy low that cycle.

Reset
REQ-027 rst_n low: state IDLE, FIFO empty, counters 0; wr_en, busy, done, overflow 0; wr_addr BASE_ADDR; wr_data 0.
REQ-028 Reset mid-epoch aborts immediately; no done; pending FIFO data discarded.

Configuration
REQ-029 Macro EEG_LOADER_DROP_COUNT_EN: when defined, adds output drop_count (8b) counting dropped samples, saturating at 255, cleared by start/reset; when undefined, port and counter absent, overflow flag only.

Verification
REQ-030 Reset, start, 3840 strobes every 4 cycles, wr_ready=1 -> 3840 writes, addr 0..3839, one done, overflow=0.
REQ-031 Samples 0x0000, 0x8000, 0xFFFF, 0x7FFF -> wr_data -2^20, 0, 2^20-32, -32.
REQ-032 wr_ready=0 for 10 cycles, strobes every cycle -> 2 held in FIFO, 3rd dropped, overflow=1, drop_count=8 (macro on), addr/data stable while stalled.
REQ-033 Extra strobes after 3840 accepted and start pulses while busy -> no additional writes, no overflow, single done.
REQ-034 rst_n low after 100 writes, then new start -> writes restart at addr 0, no done from aborted epoch.
